// File: rtl/disp_seq_ctrl.sv
// Display sequencer: snapshots NUM_VALS result words on start and presents
// them one at a time for TICK_CYCLES clocks each, with loop/pause/abort control.
module disp_seq_ctrl #(
    parameter int DATA_W      = 8,
    parameter int NUM_VALS    = 8,
    parameter int IDX_W       = 3,
    parameter int TICK_CYCLES = 200
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         pause,
    input  logic                         loop_en,
    input  logic [DATA_W*NUM_VALS-1:0]   vals_flat,
    output logic [DATA_W-1:0]            disp_val,
    output logic [IDX_W-1:0]             disp_idx,
    output logic                         busy,
    output logic                         next,
    output logic                         done
);

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TICK_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VALS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHOW   = 2'd1,
        S_PAUSED = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [DATA_W*NUM_VALS-1:0]   snap_q, snap_d;
    logic                         next_q, next_d;
    logic                         done_q, done_d;
    logic                         count_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            snap_q <= '0;
            next_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            next_q <= next_d;
            done_q <= done_d;
        end
    end

    // The resume edge out of PAUSED counts like a SHOW clock, so playback
    // time lost equals exactly the number of clocks pause was sampled high.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        snap_d   = snap_q;
        next_d   = 1'b0;
        done_d   = 1'b0;
        count_en = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_IDLE, S_HOLD: begin
                    if (start) begin
                        snap_d  = vals_flat;
                        idx_d   = '0;
                        cnt_d   = '0;
                        state_d = S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (pause) begin
                        state_d = S_PAUSED;
                    end else begin
                        count_en = 1'b1;
                    end
                end
                S_PAUSED: begin
                    if (!pause) begin
                        state_d  = S_SHOW;
                        count_en = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (count_en) begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (idx_q != LAST_IDX) begin
                        idx_d  = idx_q + IDX_W'(1);
                        next_d = 1'b1;
                    end else if (loop_en) begin
                        idx_d  = '0;
                        next_d = 1'b1;
                    end else begin
                        state_d = S_HOLD;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        busy     = (state_q == S_SHOW) || (state_q == S_PAUSED);
        disp_idx = idx_q;
        next     = next_q;
        done     = done_q;
        if (state_q == S_IDLE) begin
            disp_val = '0;
        end else begin
            disp_val = snap_q[idx_q*DATA_W +: DATA_W];
        end
    end

endmodule

// File: tb/tb_disp_seq_ctrl.sv
// Directed bench for disp_seq_ctrl: a 3-value/4-tick instance for the main
// sequencing cases and a 1-value/1-tick instance for the degenerate corner.
module tb_disp_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0, abort = 1'b0, pause = 1'b0, loop_en = 1'b0;
    logic [23:0] vals_flat = {8'h33, 8'h22, 8'h11};
    logic [7:0]  disp_val;
    logic [1:0]  disp_idx;
    logic        busy, next, done;

    logic        start2 = 1'b0, loop_en2 = 1'b0;
    logic [7:0]  vals2 = 8'h5A;
    logic [7:0]  disp_val2;
    logic [0:0]  disp_idx2;
    logic        busy2, next2, done2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    disp_seq_ctrl #(.DATA_W(8), .NUM_VALS(3), .IDX_W(2), .TICK_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .pause(pause),
        .loop_en(loop_en), .vals_flat(vals_flat), .disp_val(disp_val),
        .disp_idx(disp_idx), .busy(busy), .next(next), .done(done)
    );

    disp_seq_ctrl #(.DATA_W(8), .NUM_VALS(1), .IDX_W(1), .TICK_CYCLES(1)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .abort(1'b0), .pause(1'b0),
        .loop_en(loop_en2), .vals_flat(vals2), .disp_val(disp_val2),
        .disp_idx(disp_idx2), .busy(busy2), .next(next2), .done(done2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
    endtask

    initial begin
        // reset state
        #2;
        check("rst_disp_val", disp_val, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_next_done", {next, done}, 2'b00);
        tick(2);
        reset = 1'b1;
        tick(2);
        check("idle_disp_val", disp_val, 8'h00);
        check("idle_idx", disp_idx, 0);
        check("idle_busy", busy, 0);

        // 1: one-shot
        loop_en = 1'b0;
        pulse_start();
        check("t1_e0_val", disp_val, 8'h11);
        check("t1_e0_busy", busy, 1);
        tick(3);
        check("t1_e3_val", disp_val, 8'h11);
        check("t1_e3_next", next, 0);
        tick(1);
        check("t1_e4_val", disp_val, 8'h22);
        check("t1_e4_idx", disp_idx, 1);
        check("t1_e4_next", next, 1);
        tick(1);
        check("t1_e5_next", next, 0);
        tick(3);
        check("t1_e8_val", disp_val, 8'h33);
        check("t1_e8_next", next, 1);
        tick(3);
        check("t1_e11_busy", busy, 1);
        check("t1_e11_done", done, 0);
        tick(1);
        check("t1_e12_done", done, 1);
        check("t1_e12_next", next, 0);
        check("t1_e12_busy", busy, 0);
        check("t1_e12_val", disp_val, 8'h33);
        tick(1);
        check("t1_e13_done", done, 0);
        check("t1_e13_val", disp_val, 8'h33);

        // 2: loop, restarted from HOLD
        loop_en = 1'b1;
        pulse_start();
        check("t2_e0_val", disp_val, 8'h11);
        tick(4);
        check("t2_e4_idx", disp_idx, 1);
        tick(8);
        check("t2_e12_idx", disp_idx, 0);
        check("t2_e12_val", disp_val, 8'h11);
        check("t2_e12_next_done", {next, done}, 2'b10);
        check("t2_e12_busy", busy, 1);
        tick(12);
        check("t2_e24_next", next, 1);
        check("t2_e24_idx", disp_idx, 0);
        do_abort();
        check("t2_abort_busy", busy, 0);

        // 3: pause for 10 cycles, 2 cycles into idx 1
        loop_en = 1'b0;
        pulse_start();
        tick(6);
        check("t3_e6_val", disp_val, 8'h22);
        pause = 1'b1;
        tick(6);
        check("t3_e12_val", disp_val, 8'h22);
        check("t3_e12_busy", busy, 1);
        tick(4);
        check("t3_e16_val", disp_val, 8'h22);
        pause = 1'b0;
        tick(1);
        check("t3_e17_val", disp_val, 8'h22);
        check("t3_e17_next", next, 0);
        tick(1);
        check("t3_e18_val", disp_val, 8'h33);
        check("t3_e18_idx", disp_idx, 2);
        check("t3_e18_next", next, 1);
        do_abort();

        // 4: abort mid-sequence, start+abort, snapshot isolation
        pulse_start();
        tick(6);
        check("t4_e6_val", disp_val, 8'h22);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("t4_e7_val", disp_val, 8'h00);
        check("t4_e7_idx", disp_idx, 0);
        check("t4_e7_busy_done", {busy, done}, 2'b00);
        tick(1);
        check("t4_e8_done", done, 0);
        start = 1'b1;
        abort = 1'b1;
        tick(1);
        start = 1'b0;
        abort = 1'b0;
        check("t4_sa_busy", busy, 0);
        check("t4_sa_val", disp_val, 8'h00);
        pulse_start();
        vals_flat = {8'hCC, 8'hBB, 8'hAA};
        check("t4_snap_e0", disp_val, 8'h11);
        tick(4);
        check("t4_snap_e4", disp_val, 8'h22);
        tick(4);
        check("t4_snap_e8", disp_val, 8'h33);
        tick(4);
        check("t4_snap_e12_done", done, 1);
        check("t4_snap_e12_val", disp_val, 8'h33);
        pulse_start();
        check("t4_new_e0", disp_val, 8'hAA);
        tick(4);
        check("t4_new_e4", disp_val, 8'hBB);
        tick(4);
        check("t4_new_e8", disp_val, 8'hCC);
        do_abort();

        // 5: asynchronous reset mid-cycle
        pulse_start();
        tick(5);
        check("t5_e5_busy", busy, 1);
        #4;
        reset = 1'b0;
        #1;
        check("t5_rst_val", disp_val, 8'h00);
        check("t5_rst_idx", disp_idx, 0);
        check("t5_rst_flags", {busy, next, done}, 3'b000);
        tick(2);
        reset = 1'b1;
        tick(5);
        check("t5_post_busy", busy, 0);
        check("t5_post_val", disp_val, 8'h00);

        // 6: NUM_VALS=1, TICK_CYCLES=1
        loop_en2 = 1'b0;
        start2 = 1'b1;
        tick(1);
        start2 = 1'b0;
        check("t6_e0_val", disp_val2, 8'h5A);
        check("t6_e0_busy", busy2, 1);
        tick(1);
        check("t6_e1_done", done2, 1);
        check("t6_e1_busy", busy2, 0);
        check("t6_e1_val", disp_val2, 8'h5A);
        tick(1);
        check("t6_e2_done", done2, 0);
        check("t6_e2_val", disp_val2, 8'h5A);
        loop_en2 = 1'b1;
        start2 = 1'b1;
        tick(1);
        start2 = 1'b0;
        check("t6_l_e0_next", next2, 0);
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            check($sformatf("t6_l_e%0d_next", i), next2, 1);
            check($sformatf("t6_l_e%0d_idx", i), disp_idx2, 0);
            check($sformatf("t6_l_e%0d_done", i), done2, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/disp_seq_ctrl.md
Name: disp_seq_ctrl

Overview:
- Parametrised display sequencer for the 7-seg/LED result path.
- On start, snapshots NUM_VALS result words and presents them one at a time, each for TICK_CYCLES clocks.
- Supports one-shot or looping playback, pause/resume, and abort.
- Emits `next`/`done` pulses for downstream display and top-level control logic.

Parameters:
- DATA_W, 8: width of each displayed value.
- NUM_VALS, 8: number of values in a sequence (>=1).
- IDX_W, 3: index width; must equal max(1, clog2(NUM_VALS)).
- TICK_CYCLES, 200: clocks per displayed value (>=1). Use 200 for simulation, 100_000_000 for the 1 s board build.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin sequence; sampled in IDLE and HOLD only.
- abort  in  1  return to IDLE from any state.
- pause  in  1  level; freezes playback while high.
- loop_en  in  1  1 = wrap to index 0 after last value; 0 = one-shot.
- vals_flat  in  DATA_W*NUM_VALS  packed values; value i at bits [i*DATA_W +: DATA_W].
- disp_val  out  DATA_W  currently displayed value; 0 in IDLE.
- disp_idx  out  IDX_W  index of displayed value.
- busy  out  1  high in SHOW or PAUSED.
- next  out  1  one-cycle pulse after each index advance, including wrap.
- done  out  1  one-cycle pulse on entering HOLD.

Behaviour:
- Reset (async, active-low): state=IDLE, cnt=0, idx=0, snapshot=0, disp_val=0, disp_idx=0, busy=0, next=0, done=0. Takes effect immediately, no clock needed; applies mid-operation.
- Outputs derive from registers only; no combinational path from inputs to outputs.
- Register widths: cnt width = max(1, clog2(TICK_CYCLES)). adv = (state==SHOW) && !pause && (cnt==TICK_CYCLES-1).
- IDLE:
  - start=1 -> capture vals_flat into snapshot, idx=0, cnt=0, go to SHOW.
  - Value 0 is visible in the cycle after the start edge.
- SHOW:
  - pause=0: cnt increments each clock.
  - On adv: cnt=0, and one of:
    - idx<NUM_VALS-1 -> idx+1, next=1.
    - idx==NUM_VALS-1 and loop_en=1 -> idx=0, next=1.
    - idx==NUM_VALS-1 and loop_en=0 -> go to HOLD, done=1, idx unchanged.
  - pause=1 -> go to PAUSED; cnt holds its value (not cleared).
- PAUSED:
  - cnt and idx frozen; disp_val unchanged.
  - pause=0 -> back to SHOW; counting resumes from the held cnt.
- HOLD:
  - Last value stays displayed; busy=0.
  - start=1 -> re-snapshot vals_flat, idx=0, cnt=0, go to SHOW (restart).
- Priority: abort over all other inputs. abort=1 in any state -> next edge IDLE, cnt=0, idx=0, disp_val=0, no done pulse. abort with start in the same cycle -> IDLE.
- start is ignored in SHOW and PAUSED.
- loop_en is sampled at the final-index adv edge only; changing it mid-sequence is legal.
- NUM_VALS=1: one-shot goes to HOLD after the first TICK_CYCLES. Loop mode re-pulses `next` every TICK_CYCLES with idx staying 0.
- TICK_CYCLES=1: advance on every SHOW clock.
- vals_flat changes after the snapshot edge have no effect on display until the next start.
- next and done are registered, high exactly one cycle, never both in the same cycle.

Test Plan:
Common setup: TICK_CYCLES=4, NUM_VALS=3, DATA_W=8, vals_flat={8'h33,8'h22,8'h11}; start is pulsed at edge E0.
1. One-shot, loop_en=0:
   - 0x11 shown E0–E4, 0x22 E4–E8, 0x33 from E8.
   - next high one cycle after E4 and E8.
   - HOLD at E12 with done high one cycle; disp_val stays 0x33, busy=0.
2. Loop, loop_en=1:
   - At E12 idx=0, disp_val=0x11, next=1, done=0.
   - Sequence repeats with a period of 12 cycles.
3. Pause:
   - Raise pause for 10 cycles starting 2 cycles into idx 1.
   - 0x22 is displayed 14 cycles total; the advance to 0x33 lands at E18.
4. Abort and snapshot:
   - abort at E6 -> after E7 disp_val=0, disp_idx=0, busy=0, no done.
   - start+abort in the same cycle -> stays IDLE.
   - Changing vals_flat to {8'hCC,8'hBB,8'hAA} after E0 leaves the display at 0x11/0x22/0x33.
   - start from HOLD then shows 0xAA/0xBB/0xCC.
5. Async reset:
   - Assert reset at E5 plus half a cycle (no clock edge) -> all outputs 0 immediately.
   - After release, the sequencer stays IDLE until start.
6. Edge parameters:
   - NUM_VALS=1, TICK_CYCLES=1, vals=8'h5A: one-shot gives done after E1, disp_val holds 0x5A.
   - Loop mode gives next every cycle with idx=0.
